// File: rtl/imm_enc.sv
// Immediate field encoder: classifies a 32-bit constant into the cheapest decodable
// immediate form, or splits it into an upper/lower pair whose decoded values sum to it.
module imm_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_a,
  output logic [4:0]  out_b,
  output logic [10:0] out_c,
  output logic [1:0]  imm_sel_out,
  output logic        out_last
);

  typedef enum logic [1:0] {
    IDLE,
    ONE,
    HI,
    LO
  } state_e;

  localparam logic [1:0] SEL_ZERO  = 2'b00;
  localparam logic [1:0] SEL_UPPER = 2'b01;
  localparam logic [1:0] SEL_SEXT16 = 2'b10;
  localparam logic [1:0] SEL_SEXT21 = 2'b11;

  state_e      state_q;
  logic        valid_q;
  logic        last_q;
  logic [1:0]  sel_q;
  logic [4:0]  a_q;
  logic [4:0]  b_q;
  logic [10:0] c_q;
  logic [15:0] lo_q;

  logic        is_zero;
  logic        fits16;
  logic        fits21;
  logic        low_zero;
  logic        is_pair;
  logic [15:0] hi_adj;
  logic [1:0]  first_sel;
  logic [20:0] first_f;
  logic        accept;

  // First-match classification of the incoming constant into a {c,b,a} field image.
  always_comb begin
    is_zero   = (in_imm == 32'd0);
    fits16    = (&in_imm[31:15]) | ~(|in_imm[31:15]);
    fits21    = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    low_zero  = (in_imm[15:0] == 16'd0);
    hi_adj    = in_imm[31:16] + {15'd0, in_imm[15]};
    first_sel = SEL_ZERO;
    first_f   = 21'd0;
    is_pair   = 1'b0;
    if (is_zero) begin
      first_sel = SEL_ZERO;
      first_f   = 21'd0;
    end else if (fits16) begin
      first_sel = SEL_SEXT16;
      first_f   = {in_imm[15:0], 5'd0};
    end else if (fits21) begin
      first_sel = SEL_SEXT21;
      first_f   = in_imm[20:0];
    end else if (low_zero) begin
      first_sel = SEL_UPPER;
      first_f   = {in_imm[31:16], 5'd0};
    end else begin
      // The upper half absorbs bit 15 because the LO beat is sign-extended.
      first_sel = SEL_UPPER;
      first_f   = {hi_adj, 5'd0};
      is_pair   = 1'b1;
    end
  end

  assign in_ready = (state_q == IDLE) |
                    (((state_q == ONE) | (state_q == LO)) & out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sel_q   <= SEL_ZERO;
      a_q     <= 5'd0;
      b_q     <= 5'd0;
      c_q     <= 11'd0;
      lo_q    <= 16'd0;
    end else begin
      unique case (state_q)
        IDLE, ONE, LO: begin
          // A final beat leaving and a new accept share the same edge, so no bubble.
          if ((state_q == IDLE) || out_ready) begin
            if (accept) begin
              state_q <= is_pair ? HI : ONE;
              valid_q <= 1'b1;
              last_q  <= ~is_pair;
              sel_q   <= first_sel;
              c_q     <= first_f[20:10];
              b_q     <= first_f[9:5];
              a_q     <= first_f[4:0];
              lo_q    <= in_imm[15:0];
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end
          end
        end
        HI: begin
          if (out_ready) begin
            state_q <= LO;
            valid_q <= 1'b1;
            last_q  <= 1'b1;
            sel_q   <= SEL_SEXT16;
            c_q     <= lo_q[15:5];
            b_q     <= lo_q[4:0];
            a_q     <= 5'd0;
          end
        end
      endcase
    end
  end

  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign imm_sel_out = sel_q;
  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_c       = c_q;

endmodule

// File: tb/tb_imm_enc.sv
// Scoreboard bench for imm_enc: a range-based reference model queues expected beats,
// and a monitor pops and compares them and checks that each constant's beats decode back to it.
module tb_imm_enc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_a;
  logic [4:0]  out_b;
  logic [10:0] out_c;
  logic [1:0]  imm_sel_out;
  logic        out_last;

  int total;
  int bad;

  typedef struct packed {
    logic [1:0]  sel;
    logic [20:0] f;
    logic        last;
    logic [31:0] v;
  } beat_t;

  beat_t       expQ[$];
  logic [31:0] accSum;

  imm_enc dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_imm(in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a(out_a),
    .out_b(out_b),
    .out_c(out_c),
    .imm_sel_out(imm_sel_out),
    .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pick the encoding from the numeric range the constant lies in.
  function automatic void pushExpected(input logic [31:0] v);
    int signed  s;
    logic [32:0] t;
    beat_t      b;
    s      = $signed(v);
    b.v    = v;
    b.last = 1'b1;
    if (v == 32'd0) begin
      b.sel = 2'b00;
      b.f   = 21'd0;
    end else if (s >= -32768 && s <= 32767) begin
      b.sel = 2'b10;
      b.f   = {v[15:0], 5'd0};
    end else if (s >= -(1 << 20) && s < (1 << 20)) begin
      b.sel = 2'b11;
      b.f   = v[20:0];
    end else if ((v % 32'd65536) == 32'd0) begin
      b.sel = 2'b01;
      b.f   = {v[31:16], 5'd0};
    end else begin
      t      = {1'b0, v} + 33'h0_0000_8000;
      b.sel  = 2'b01;
      b.f    = {t[31:16], 5'd0};
      b.last = 1'b0;
      expQ.push_back(b);
      b.sel  = 2'b10;
      b.f    = {v[15:0], 5'd0};
      b.last = 1'b1;
    end
    expQ.push_back(b);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkBeat(input string name, input logic [1:0] sel, input logic [15:0] cb,
                           input logic [4:0] a, input logic last);
    checkOutput({name, " valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput(name, {8'd0, imm_sel_out, out_c, out_b, out_a, out_last},
                {8'd0, sel, cb, a, last});
  endtask

  // Offer one constant until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] v, input int readyPct);
    int   waitCycles;
    logic acc;
    waitCycles = 0;
    acc        = 1'b0;
    in_valid   = 1'b1;
    in_imm     = v;
    while (!acc) begin
      out_ready = ($urandom_range(99) < readyPct);
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        pushExpected(v);
      end
      @(posedge clk);
      #1;
      waitCycles++;
      if (!acc && waitCycles > 100) begin
        total++;
        bad++;
        $display("[TB] FAIL accept timeout: in_ready stuck at 0, want 1 within 100 cycles");
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_imm   = $urandom;
  endtask

  task automatic releaseBeat();
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // Monitor: every handshake beat is checked against the head of the scoreboard.
  always @(negedge clk) begin
    beat_t       e;
    logic [31:0] dec;
    if (!rst && out_valid && out_ready) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected beat: got sel=%0h c=%0h b=%0h a=%0h, want none",
                 imm_sel_out, out_c, out_b, out_a);
      end else begin
        e = expQ.pop_front();
        if ({imm_sel_out, out_c, out_b, out_a, out_last} !== {e.sel, e.f, e.last}) begin
          bad++;
          $display("[TB] FAIL beat v=0x%08h: got sel=%0h f=0x%06h last=%0b, want sel=%0h f=0x%06h last=%0b",
                   e.v, imm_sel_out, {out_c, out_b, out_a}, out_last, e.sel, e.f, e.last);
        end
        case (imm_sel_out)
          2'b00:   dec = 32'd0;
          2'b01:   dec = {out_c, out_b, 16'h0000};
          2'b10:   dec = {{16{out_c[10]}}, out_c, out_b};
          default: dec = {{11{out_c[10]}}, out_c, out_b, out_a};
        endcase
        accSum = accSum + dec;
        if (out_last) begin
          total++;
          if (accSum !== e.v) begin
            bad++;
            $display("[TB] FAIL decoded sum: got 0x%08h, want 0x%08h", accSum, e.v);
          end
          accSum = 32'd0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] v;
    int          guard;
    total     = 0;
    bad       = 0;
    accSum    = 32'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_imm    = 32'd0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset out_last", {31'd0, out_last}, 32'd0);
    checkOutput("reset fields", {9'd0, imm_sel_out, out_c, out_b, out_a}, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed encodings");
    applyStimulus(32'h0000_0000, 0);
    @(negedge clk);
    checkBeat("zero", 2'b00, 16'h0000, 5'h00, 1'b1);
    releaseBeat();
    applyStimulus(32'hFFFF_FFFE, 0);
    @(negedge clk);
    checkBeat("sext16", 2'b10, 16'hFFFE, 5'h00, 1'b1);
    releaseBeat();
    applyStimulus(32'h000F_FFFF, 0);
    @(negedge clk);
    checkBeat("sext21", 2'b11, 16'h7FFF, 5'h1F, 1'b1);
    releaseBeat();
    applyStimulus(32'h1234_0000, 0);
    @(negedge clk);
    checkBeat("upper", 2'b01, 16'h1234, 5'h00, 1'b1);
    releaseBeat();
    applyStimulus(32'h1234_8765, 0);
    @(negedge clk);
    checkBeat("pair hi", 2'b01, 16'h1235, 5'h00, 1'b0);
    releaseBeat();
    @(negedge clk);
    checkBeat("pair lo", 2'b10, 16'h8765, 5'h00, 1'b1);
    releaseBeat();

    $display("[TB] backpressure in HI");
    applyStimulus(32'h7FFF_8000, 0);
    repeat (3) begin
      @(negedge clk);
      checkBeat("held hi", 2'b01, 16'h8000, 5'h00, 1'b0);
      checkOutput("held in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    releaseBeat();
    @(negedge clk);
    checkBeat("released lo", 2'b10, 16'h8000, 5'h00, 1'b1);
    releaseBeat();

    $display("[TB] streaming");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_imm   = (i == 0) ? 32'h0000_0005 : (i == 1) ? 32'h1234_0000 : 32'h0000_0001;
      @(negedge clk);
      checkOutput("stream in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) checkOutput("stream out_valid", {31'd0, out_valid}, 32'd1);
      if (in_ready) pushExpected(in_imm);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("stream last out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b0;

    $display("[TB] reset mid-pair");
    applyStimulus(32'h1234_8765, 0);
    @(negedge clk);
    checkBeat("pre-reset hi", 2'b01, 16'h1235, 5'h00, 1'b0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_imm   = 32'h0000_0005;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    expQ.delete();
    accSum   = 32'd0;
    @(negedge clk);
    checkOutput("post-reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("post-reset fields", {8'd0, imm_sel_out, out_c, out_b, out_a, out_last}, 32'd0);
    checkOutput("post-reset in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("no lo after reset", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
    end

    $display("[TB] random stream");
    for (int n = 0; n < 10000; n++) begin
      r = $urandom;
      case ($urandom_range(5))
        0:       v = 32'd0;
        1:       v = {{16{r[15]}}, r[15:0]};
        2:       v = {{11{r[20]}}, r[20:0]};
        3:       v = {r[31:16], 16'h0000};
        4:       v = {16'hFFFF, r[15:0]};
        default: v = r;
      endcase
      if ($urandom_range(9) == 0) begin
        out_ready = ($urandom_range(99) < 70);
        @(posedge clk);
        #1;
      end
      applyStimulus(v, 70);
    end

    out_ready = 1'b1;
    guard     = 0;
    while ((expQ.size() != 0 || out_valid) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("drain remaining beats", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
